// File: rtl/mac_bus_timing.sv
// mac_bus_timing: clk8/E enables from clk32, video line/frame counters and the
// RAM slot strobes and fetch addresses handed to the data controller.
module mac_bus_timing #(
  parameter int          H_TOTAL    = 352,
  parameter int          H_ACTIVE   = 256,
  parameter int          V_TOTAL    = 370,
  parameter int          V_ACTIVE   = 342,
  parameter int          SOUND_SLOT = 70,
  parameter logic [21:0] VIDEO_BASE = 22'h3FA700,
  parameter logic [21:0] SOUND_BASE = 22'h3FFD00,
  parameter int          E_DIV      = 10
) (
  input  logic        clk32,
  input  logic        _systemReset,
  input  logic        vid_alt,
  input  logic        snd_alt,
  output logic        clk8_en_p,
  output logic        clk8_en_n,
  output logic        E,
  output logic        E_rising,
  output logic        E_falling,
  output logic [1:0]  busCycle,
  output logic        videoBusControl,
  output logic        cpuBusControl,
  output logic        memoryLatch,
  output logic        loadPixels,
  output logic        loadSound,
  output logic        _hblank,
  output logic        _vblank,
  output logic [21:0] videoAddr,
  output logic [21:0] soundAddr
);
  localparam logic [8:0] HL = 9'(H_TOTAL - 1);
  localparam logic [8:0] HA = 9'(H_ACTIVE);
  localparam logic [8:0] VL = 9'(V_TOTAL - 1);
  localparam logic [8:0] VA = 9'(V_ACTIVE);
  localparam logic [6:0] SS = 7'(SOUND_SLOT);
  localparam logic [3:0] EL = 4'(E_DIV - 1);
  localparam logic [3:0] EH = 4'(E_DIV - 4);
  logic [1:0]  div;
  logic [8:0]  hcount, line, nh, nl;
  logic [3:0]  ecount;
  logic        vid_sel, is_vid, n_video, n_sound;
  logic [21:0] vbase;
  assign clk8_en_p     = div == 2'd3;
  assign clk8_en_n     = div == 2'd1;
  assign busCycle      = hcount[1:0];
  assign cpuBusControl = !videoBusControl;
  assign memoryLatch   = clk8_en_n && hcount[1:0] == 2'd3;
  assign loadSound     = hcount[1:0] == 2'd3 && hcount[8:2] == SS;
  assign E             = ecount >= EH;
  assign E_rising      = clk8_en_p && ecount == EH - 4'd1;
  assign E_falling     = clk8_en_p && ecount == EL;
  // Everything below looks at the counter values about to take effect, so the
  // registered flags line up with hcount/line rather than lagging a clk8.
  always_comb begin
    nh      = hcount == HL ? 9'd0 : hcount + 9'd1;
    nl      = hcount != HL ? line : line == VL ? 9'd0 : line + 9'd1;
    n_video = nh < HA && nl < VA && !nh[2];
    n_sound = nh[8:2] == SS;
    vbase   = (nh == 9'd0 ? vid_alt : vid_sel) ? VIDEO_BASE : VIDEO_BASE - 22'h8000;
  end
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      div             <= '0;
      hcount          <= '0;
      line            <= '0;
      ecount          <= '0;
      vid_sel         <= 1'b1;
      is_vid          <= 1'b1;
      videoBusControl <= 1'b1;
      _hblank         <= 1'b1;
      _vblank         <= 1'b1;
      loadPixels      <= 1'b0;
      videoAddr       <= VIDEO_BASE;
      soundAddr       <= SOUND_BASE;
    end else begin
      div        <= div + 2'd1;
      loadPixels <= memoryLatch && is_vid;
      if (clk8_en_p) begin
        hcount  <= nh;
        line    <= nl;
        ecount  <= ecount == EL ? 4'd0 : ecount + 4'd1;
        _hblank <= nh < HA;
        _vblank <= nl < VA;
        if (nh[1:0] == 2'd0) begin
          is_vid          <= n_video;
          videoBusControl <= n_video || n_sound;
        end
        if (nh[1:0] == 2'd0 && n_video)
          videoAddr <= vbase + {4'd0, nl, 9'd0} / 22'd8 + {15'd0, nh[8:3], 1'b0};
        if (nh == 9'd0) begin
          vid_sel   <= vid_alt;
          soundAddr <= (snd_alt ? SOUND_BASE - 22'h5C00 : SOUND_BASE) + {12'd0, nl, 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_bus_timing.sv
// tb_mac_bus_timing: directed checks of clock enables, slot strobes, addresses,
// E clock, async reset, and frame-level blanking on a short-frame instance.
module tb_mac_bus_timing;
  logic        clk32 = 1'b0, rst_n = 1'b0, vid_alt = 1'b1, snd_alt = 1'b0;
  logic        en_p, en_n, e, e_r, e_f, vbc, cbc, ml, lp, ls, hb, vb;
  logic [1:0]  bc;
  logic [21:0] va, sa;
  logic        f_en_p, f_en_n, f_e, f_e_r, f_e_f, f_vbc, f_cbc, f_ml, f_lp, f_ls, f_hb, f_vb;
  logic [1:0]  f_bc;
  logic [21:0] f_va, f_sa;
  int pass_n = 0, total_n = 0, cyc = 0;

  mac_bus_timing dut (
    .clk32(clk32), ._systemReset(rst_n), .vid_alt(vid_alt), .snd_alt(snd_alt),
    .clk8_en_p(en_p), .clk8_en_n(en_n), .E(e), .E_rising(e_r), .E_falling(e_f),
    .busCycle(bc), .videoBusControl(vbc), .cpuBusControl(cbc), .memoryLatch(ml),
    .loadPixels(lp), .loadSound(ls), ._hblank(hb), ._vblank(vb),
    .videoAddr(va), .soundAddr(sa));

  // Short frame (6 lines, 4 active) so frame-level behaviour fits the cycle budget.
  mac_bus_timing #(.V_TOTAL(6), .V_ACTIVE(4)) dut_f (
    .clk32(clk32), ._systemReset(rst_n), .vid_alt(vid_alt), .snd_alt(snd_alt),
    .clk8_en_p(f_en_p), .clk8_en_n(f_en_n), .E(f_e), .E_rising(f_e_r), .E_falling(f_e_f),
    .busCycle(f_bc), .videoBusControl(f_vbc), .cpuBusControl(f_cbc), .memoryLatch(f_ml),
    .loadPixels(f_lp), .loadSound(f_ls), ._hblank(f_hb), ._vblank(f_vb),
    .videoAddr(f_va), .soundAddr(f_sa));

  always #5 clk32 = ~clk32;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk32);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total_n++; if ({en_p, en_n, e, e_r, e_f, ml, lp, ls} !== 8'b0) $display("FAIL reset_pulses: got %b want 00000000", {en_p, en_n, e, e_r, e_f, ml, lp, ls}); else pass_n++;
    total_n++; if ({hb, vb, vbc, cbc, bc} !== 6'b111000) $display("FAIL reset_levels: got %b want 111000", {hb, vb, vbc, cbc, bc}); else pass_n++;
    total_n++; if (va !== 22'h3FA700) $display("FAIL reset_videoAddr: got %h want 3fa700", va); else pass_n++;
    total_n++; if (sa !== 22'h3FFD00) $display("FAIL reset_soundAddr: got %h want 3ffd00", sa); else pass_n++;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_clk_div();
    for (int k = 0; k < 16; k++) begin
      total_n++;
      if ({en_p, en_n} !== {k % 4 == 3, k % 4 == 1}) $display("FAIL clk_div cycle %0d: got p/n %b%b want %b%b", k, en_p, en_n, k % 4 == 3, k % 4 == 1);
      else pass_n++;
      tick();
    end
  endtask

  task automatic test_line0();
    int n = 0, mls = 0;
    logic pml = 1'b0;
    release_reset();
    while (cyc < 1400) begin
      if (lp) begin
        total_n++;
        if (va !== 22'h3FA700 + 22'(2 * n) || !pml) $display("FAIL line0_pixel %0d: addr %h prev_latch %b want %h 1", n, va, pml, 22'h3FA700 + 22'(2 * n));
        else pass_n++;
        n++;
      end
      if (cyc == 20) begin
        total_n++; if ({vbc, cbc} !== 2'b01) $display("FAIL cpu_slot: got %b want 01", {vbc, cbc}); else pass_n++;
      end
      if (cyc == 1120) begin
        total_n++; if ({vbc, ls} !== 2'b10) $display("FAIL sound_slot_bc0: got %b want 10", {vbc, ls}); else pass_n++;
      end
      if (cyc == 1132) begin
        total_n++; if (ls !== 1'b1) $display("FAIL sound_slot_bc3: got %b want 1", ls); else pass_n++;
      end
      mls += int'(ml);
      pml = ml;
      tick();
    end
    total_n++; if (n !== 32) $display("FAIL line0_pixel_count: got %0d want 32", n); else pass_n++;
    total_n++; if (mls !== 87) $display("FAIL line0_latch_count: got %0d want 87", mls); else pass_n++;
  endtask

  task automatic test_vid_alt();
    int n = 0;
    vid_alt = 1'b0;
    while (cyc < 2808) begin
      if (lp) begin
        total_n++;
        if (va !== 22'h3F2740 + 22'(2 * n)) $display("FAIL alt_line1 %0d: got %h want %h", n, va, 22'h3F2740 + 22'(2 * n));
        else pass_n++;
        n++;
        if (n == 8) vid_alt = 1'b1;
      end
      tick();
    end
    total_n++; if (n !== 32) $display("FAIL alt_line1_count: got %0d want 32", n); else pass_n++;
  endtask

  task automatic test_e_clock();
    int rise = 0, fall = 0, high = 0, errs = 0, misal = 0, idx;
    for (int k = 0; k < 160; k++) begin
      idx = cyc / 4;
      if (e !== (idx % 10 >= 6) || e_r !== (cyc % 4 == 3 && idx % 10 == 5) || e_f !== (cyc % 4 == 3 && idx % 10 == 9)) errs++;
      if ((e_r || e_f) && !en_p) misal++;
      rise += int'(e_r);
      fall += int'(e_f);
      if (en_p && e) high++;
      tick();
    end
    total_n++; if (errs !== 0) $display("FAIL e_waveform: got %0d bad cycles want 0", errs); else pass_n++;
    total_n++; if (rise !== 4 || fall !== 4) $display("FAIL e_edges: got rise %0d fall %0d want 4 4", rise, fall); else pass_n++;
    total_n++; if (high !== 16) $display("FAIL e_high_clk8: got %0d want 16", high); else pass_n++;
    total_n++; if (misal !== 0) $display("FAIL e_alignment: got %0d want 0", misal); else pass_n++;
  endtask

  task automatic test_async_reset();
    while (cyc < 5437) tick();
    total_n++; if ({en_n, ml, hb, cbc, bc, e} !== 7'b1101111) $display("FAIL pre_reset_levels: got %b want 1101111", {en_n, ml, hb, cbc, bc, e}); else pass_n++;
    total_n++; if (va !== 22'h3FA7FE || sa !== 22'h3FFD06) $display("FAIL pre_reset_addr: got %h %h want 3fa7fe 3ffd06", va, sa); else pass_n++;
    rst_n = 1'b0;
    #1;
    total_n++; if ({en_p, en_n, e, e_r, e_f, ml, lp, ls} !== 8'b0) $display("FAIL async_pulses: got %b want 00000000", {en_p, en_n, e, e_r, e_f, ml, lp, ls}); else pass_n++;
    total_n++; if ({hb, vb, vbc, cbc, bc} !== 6'b111000) $display("FAIL async_levels: got %b want 111000", {hb, vb, vbc, cbc, bc}); else pass_n++;
    total_n++; if (va !== 22'h3FA700 || sa !== 22'h3FFD00) $display("FAIL async_addr: got %h %h want 3fa700 3ffd00", va, sa); else pass_n++;
    release_reset();
    while (!lp && cyc < 100) tick();
    total_n++; if (!lp || cyc !== 14 || va !== 22'h3FA700 || bc !== 2'd3) $display("FAIL first_slot: lp %b cycle %0d addr %h bc %0d want 1 14 3fa700 3", lp, cyc, va, bc); else pass_n++;
  endtask

  task automatic test_frame();
    int vbl = 0, hbl = 0, lsw = 0, lsc = 0, vfall = -1;
    logic pls = 1'b0, pvb = 1'b1;
    snd_alt = 1'b0;
    release_reset();
    while (cyc < 8452) begin
      if (cyc < 8448) begin
        if (f_en_p) begin
          vbl += int'(!f_vb);
          hbl += int'(!f_hb);
        end
        if (f_ls && !pls) lsw++;
        lsc += int'(f_ls);
        if (!f_vb && pvb && vfall < 0) vfall = cyc;
      end
      if (cyc == 7100) begin
        total_n++; if (f_sa !== 22'h3FFD0A) $display("FAIL sound_last_line: got %h want 3ffd0a", f_sa); else pass_n++;
      end
      if (cyc == 8000) snd_alt = 1'b1;
      pls = f_ls;
      pvb = f_vb;
      tick();
    end
    total_n++; if (vbl !== 704) $display("FAIL vblank_clk8: got %0d want 704", vbl); else pass_n++;
    total_n++; if (hbl !== 576) $display("FAIL hblank_clk8: got %0d want 576", hbl); else pass_n++;
    total_n++; if (lsw !== 6 || lsc !== 24) $display("FAIL load_sound: got %0d windows %0d cycles want 6 24", lsw, lsc); else pass_n++;
    total_n++; if (vfall !== 5632) $display("FAIL vblank_fall: got cycle %0d want 5632", vfall); else pass_n++;
    total_n++; if (f_sa !== 22'h3FA100 || f_vb !== 1'b1) $display("FAIL frame_wrap: got %h vb %b want 3fa100 1", f_sa, f_vb); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_clk_div();
    test_line0();
    test_vid_alt();
    test_e_clock();
    test_async_reset();
    test_frame();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
